// File: rtl/ieee_fp_pkg.sv
// Shared types and constants for the binary32 adder front end.
package ieee_fp_pkg;

   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int FIELD_W  = 27;
   localparam int EXP_BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } align_state_t;

endpackage

// File: rtl/ieee_unpack.sv
// Combinational unpack of one binary32 operand into a 27-bit
// {hidden, frac, G, R, S} field plus special-value classification.
// Optional macro DENORM_EN: keep subnormals (hidden bit 0) instead of
// flushing exp=0 operands to zero.
module ieee_unpack
   import ieee_fp_pkg::*;
(
   input  fp32_t              op,
   output logic               hidden,
   output logic [FIELD_W-1:0] field,
   output logic               is_nan,
   output logic               is_inf,
   output logic               is_zero
);

   // Classify the operand and build its mantissa field with G/R/S cleared.
   always_comb begin
      hidden  = 1'b0;
      field   = {FIELD_W{1'b0}};
      is_nan  = 1'b0;
      is_inf  = 1'b0;
      is_zero = 1'b0;
      if (op.exp == EXP_MAX) begin
         hidden = 1'b1;
         field  = {1'b1, op.frac, 3'b000};
         is_nan = (op.frac != 23'd0);
         is_inf = (op.frac == 23'd0);
      end else if (op.exp != 8'd0) begin
         hidden = 1'b1;
         field  = {1'b1, op.frac, 3'b000};
      end else begin
`ifdef DENORM_EN
         field   = {1'b0, op.frac, 3'b000};
         is_zero = (op.frac == 23'd0);
`else
         field   = {FIELD_W{1'b0}};
         is_zero = 1'b1;
`endif
      end
   end

endmodule

// File: rtl/ieee_align_stage.sv
// Operand alignment stage for the binary32 adder: unpack, order by
// magnitude, flag specials, then right-shift the smaller mantissa with
// an iterative sticky-preserving shifter.
// Optional macro DENORM_EN: subnormals use effective exponent 1.
module ieee_align_stage
   import ieee_fp_pkg::*;
#(
   parameter int SHIFT_STEP = 1,
   parameter int MAX_SHIFT  = 26
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        number1,
   input  logic [31:0]        number2,
   input  logic               command,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   exp_out,
   output logic [FIELD_W-1:0] mant_big,
   output logic [FIELD_W-1:0] mant_small,
   output logic               big_sign,
   output logic               eff_sub,
   output logic               swapped,
   output logic               is_nan,
   output logic               is_inf,
   output logic               inf_sign
);

   localparam int CNT_W = $clog2(MAX_SHIFT + 1);
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_SHIFT);
   localparam logic [EXP_W-1:0] MAX_D  = EXP_W'(MAX_SHIFT);

   fp32_t              op_a, op_b;
   logic               hidden_a, hidden_b, zero_a, zero_b;
   logic               nan_a, nan_b, inf_a, inf_b;
   logic [FIELD_W-1:0] field_a, field_b;
   logic               unused_flags;

   logic               s2e_s, eff_sub_s, swap_s, special_s;
   logic               nan_s, inf_s, inf_sign_s, big_sign_s;
   logic [30:0]        key_a_s, key_b_s;
   logic [EXP_W-1:0]   xexp_a_s, xexp_b_s, d_s, exp_big_s;
   logic [FIELD_W-1:0] big_field_s, small_field_s, shifted_s;
   logic [CNT_W-1:0]   sc_s, step_s;

   align_state_t       state_r, state_next;
   logic [CNT_W-1:0]   remaining_r;

   assign op_a = number1;
   assign op_b = number2;
   // Hidden bit and zero flags are implied by the field; kept for visibility.
   assign unused_flags = ^{hidden_a, hidden_b, zero_a, zero_b};

   ieee_unpack u_unpack_a (
      .op      (op_a),
      .hidden  (hidden_a),
      .field   (field_a),
      .is_nan  (nan_a),
      .is_inf  (inf_a),
      .is_zero (zero_a)
   );

   ieee_unpack u_unpack_b (
      .op      (op_b),
      .hidden  (hidden_b),
      .field   (field_b),
      .is_nan  (nan_b),
      .is_inf  (inf_b),
      .is_zero (zero_b)
   );

   // Signs, magnitude ordering, shift distance and special-value flags.
   always_comb begin
      s2e_s     = number2[31] ^ ~command;
      eff_sub_s = number1[31] ^ s2e_s;
      // Flushed fraction comes from the field so the compare sees +/-0.
      key_a_s   = {op_a.exp, field_a[FIELD_W-2:3]};
      key_b_s   = {op_b.exp, field_b[FIELD_W-2:3]};
      swap_s    = (key_b_s > key_a_s);
`ifdef DENORM_EN
      xexp_a_s  = (op_a.exp == 8'd0) ? 8'd1 : op_a.exp;
      xexp_b_s  = (op_b.exp == 8'd0) ? 8'd1 : op_b.exp;
`else
      xexp_a_s  = op_a.exp;
      xexp_b_s  = op_b.exp;
`endif
      if (swap_s) begin
         d_s           = xexp_b_s - xexp_a_s;
         exp_big_s     = op_b.exp;
         big_field_s   = field_b;
         small_field_s = field_a;
         big_sign_s    = s2e_s;
      end else begin
         d_s           = xexp_a_s - xexp_b_s;
         exp_big_s     = op_a.exp;
         big_field_s   = field_a;
         small_field_s = field_b;
         big_sign_s    = number1[31];
      end
      sc_s      = (d_s > MAX_D) ? MAX_C : d_s[CNT_W-1:0];
      special_s = nan_a | nan_b | inf_a | inf_b;
      nan_s     = nan_a | nan_b | (inf_a & inf_b & eff_sub_s);
      inf_s     = ~nan_s & (inf_a | inf_b);
      if (inf_s) begin
         inf_sign_s = inf_a ? number1[31] : s2e_s;
      end else begin
         inf_sign_s = 1'b0;
      end
   end

   // One SHIFT cycle: up to SHIFT_STEP single-bit sticky shifts.
   always_comb begin
      step_s    = (remaining_r < STEP_C) ? remaining_r : STEP_C;
      shifted_s = mant_small;
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (CNT_W'(i) < step_s) begin
            shifted_s = {1'b0, shifted_s[FIELD_W-1:2], shifted_s[1] | shifted_s[0]};
         end else begin
            shifted_s = shifted_s;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state logic: skip SHIFT for specials or zero distance.
   always_comb begin
      state_next = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_next = (special_s || (sc_s == {CNT_W{1'b0}})) ? DONE : SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            if (remaining_r <= step_s) begin
               state_next = DONE;
            end else begin
               state_next = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers: capture on accept, shift in SHIFT, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining_r <= {CNT_W{1'b0}};
         exp_out     <= {EXP_W{1'b0}};
         mant_big    <= {FIELD_W{1'b0}};
         mant_small  <= {FIELD_W{1'b0}};
         big_sign    <= 1'b0;
         eff_sub     <= 1'b0;
         swapped     <= 1'b0;
         is_nan      <= 1'b0;
         is_inf      <= 1'b0;
         inf_sign    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  remaining_r <= special_s ? {CNT_W{1'b0}} : sc_s;
                  exp_out     <= exp_big_s;
                  mant_big    <= special_s ? {FIELD_W{1'b0}} : big_field_s;
                  mant_small  <= special_s ? {FIELD_W{1'b0}} : small_field_s;
                  big_sign    <= big_sign_s;
                  eff_sub     <= eff_sub_s;
                  swapped     <= swap_s;
                  is_nan      <= nan_s;
                  is_inf      <= inf_s;
                  inf_sign    <= inf_sign_s;
               end
            end
            SHIFT: begin
               mant_small  <= shifted_s;
               remaining_r <= remaining_r - step_s;
            end
            default: begin
               remaining_r <= remaining_r;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);

endmodule
